// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: state encoding and default frame constants,
// common to the receiver, transmitter and data generator.
package uart_rx_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int NB_DATA_DEF    = 8;
    localparam int NB_STOP_DEF    = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_START = 2'd1;
    localparam state_t ST_DATA  = 2'd2;
    localparam state_t ST_STOP  = 2'd3;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle (high) level so a reset never looks like a start bit.
module rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic line_sync
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta      <= 1'b1;
            line_sync <= 1'b1;
        end else begin
            meta      <= line;
            line_sync <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit qualification at half a bit,
// centre sampling of data and stop bits, one-clock done pulse per frame.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int NB_DATA    = NB_DATA_DEF,
    parameter int NB_STOP    = NB_STOP_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_s_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_error
);

    localparam int CW = (NB_STOP * OVERSAMPLE > 2) ? $clog2(NB_STOP * OVERSAMPLE) : 1;
    localparam int IW = $clog2(NB_DATA + NB_STOP);

    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(NB_DATA - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(NB_STOP - 1);

    logic               rx_s;
    state_t             state;
    logic [CW-1:0]      tick_cnt;
    logic [IW-1:0]      bit_idx;
    logic [NB_DATA-1:0] shreg;
    logic               err;
    logic               finish;

    rx_sync u_sync (
        .clk       (i_clk),
        .rst_n     (i_reset),
        .line      (i_rx),
        .line_sync (rx_s)
    );

    // finish marks the clock after the last stop sample, when the frame is
    // published and the FSM drops back to IDLE.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state         <= ST_IDLE;
            tick_cnt      <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            err           <= 1'b0;
            finish        <= 1'b0;
            o_data        <= '0;
            o_rx_done     <= 1'b0;
            o_frame_error <= 1'b0;
        end else begin
            o_rx_done <= 1'b0;
            if (finish) begin
                finish        <= 1'b0;
                o_data        <= shreg;
                o_frame_error <= err;
                o_rx_done     <= 1'b1;
                tick_cnt      <= '0;
                state         <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        tick_cnt <= '0;
                        if (!rx_s)
                            state <= ST_START;
                    end
                    ST_START: begin
                        if (i_s_tick) begin
                            if (tick_cnt == HALF_LAST) begin
                                tick_cnt <= '0;
                                bit_idx  <= '0;
                                state    <= rx_s ? ST_IDLE : ST_DATA;
                            end else begin
                                tick_cnt <= tick_cnt + 1'b1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (i_s_tick) begin
                            if (tick_cnt == FULL_LAST) begin
                                tick_cnt <= '0;
                                shreg    <= {rx_s, shreg[NB_DATA-1:1]};
                                if (bit_idx == DATA_LAST) begin
                                    bit_idx <= '0;
                                    err     <= 1'b0;
                                    state   <= ST_STOP;
                                end else begin
                                    bit_idx <= bit_idx + 1'b1;
                                end
                            end else begin
                                tick_cnt <= tick_cnt + 1'b1;
                            end
                        end
                    end
                    ST_STOP: begin
                        if (i_s_tick) begin
                            if (tick_cnt == FULL_LAST) begin
                                tick_cnt <= '0;
                                if (!rx_s)
                                    err <= 1'b1;
                                if (bit_idx == STOP_LAST)
                                    finish <= 1'b1;
                                else
                                    bit_idx <= bit_idx + 1'b1;
                            end else begin
                                tick_cnt <= tick_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx: a tick-driven line driver
// feeds frames, a queue of expected words is matched against each done pulse.
module tb_uart_rx;
    import uart_rx_pkg::*;

    logic       i_clk    = 1'b0;
    logic       i_reset  = 1'b0;
    logic       i_s_tick = 1'b0;
    logic       i_rx     = 1'b1;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_frame_error;

    uart_rx #(.NB_DATA(8), .NB_STOP(2), .OVERSAMPLE(16)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_s_tick      (i_s_tick),
        .i_rx          (i_rx),
        .o_data        (o_data),
        .o_rx_done     (o_rx_done),
        .o_frame_error (o_frame_error)
    );

    always #10 i_clk = ~i_clk;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         start_cycle;
        bit         check_latency;
    } frame_t;

    frame_t     expected_q[$];
    frame_t     got;
    int         error_count   = 0;
    int         check_count   = 0;
    int         cycle         = 0;
    int         tick_div      = 0;
    bit         tick_en       = 1'b1;
    int         done_count    = 0;
    int         expected_done = 0;
    logic [7:0] last_data     = 8'h00;
    logic       prev_done     = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    always @(posedge i_clk) cycle++;

    // One tick every fourth clock, changed on the falling edge; tick_en lets
    // a test freeze the baud generator.
    initial begin
        forever begin
            @(negedge i_clk);
            i_s_tick = tick_en && (tick_div == 3);
            tick_div = (tick_div + 1) % 4;
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            do begin
                @(posedge i_clk);
                guard++;
            end while (!i_s_tick && guard < 1000);
            if (!i_s_tick)
                checkOutput("tick_wait", i_s_tick, 1'b1);
        end
        #2;
    endtask

    // A low stop bit is released after 10 ticks so its tail is not mistaken
    // for a fresh start bit once the receiver has returned to idle.
    task automatic applyStimulus(input logic [7:0] data, input logic [1:0] stop_vals,
                                 input bit stall);
        frame_t f;
        f.data          = data;
        f.err           = (stop_vals != 2'b11);
        f.start_cycle   = cycle;
        f.check_latency = !stall;
        expected_q.push_back(f);
        expected_done++;
        i_rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            i_rx = data[i];
            if (stall && i == 3) begin
                wait_ticks(8);
                tick_en = 1'b0;
                repeat (100) @(posedge i_clk);
                #2;
                tick_en = 1'b1;
                wait_ticks(8);
            end else begin
                wait_ticks(16);
            end
        end
        for (int s = 0; s < 2; s++) begin
            i_rx = stop_vals[s];
            if (!stop_vals[s]) begin
                wait_ticks(10);
                i_rx = 1'b1;
                wait_ticks(6);
            end else begin
                wait_ticks(16);
            end
        end
        i_rx = 1'b1;
    endtask

    always @(negedge i_clk) begin
        if (prev_done)
            checkOutput("done_width", o_rx_done, 1'b0);
        if (o_rx_done) begin
            done_count++;
            if (expected_q.size() == 0) begin
                checkOutput("spurious_done", o_rx_done, 1'b0);
            end else begin
                got = expected_q.pop_front();
                checkOutput("data", o_data, got.data);
                checkOutput("frame_error", o_frame_error, got.err);
                if (got.check_latency)
                    checkOutput("done_latency",
                                (cycle - got.start_cycle >= 665) && (cycle - got.start_cycle <= 681),
                                1'b1);
                last_data = got.data;
            end
        end
        prev_done = o_rx_done;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #90;
        checkOutput("reset_data", o_data, 8'h00);
        checkOutput("reset_done", o_rx_done, 1'b0);
        checkOutput("reset_ferr", o_frame_error, 1'b0);
        checkOutput("reset_state", dut.state, ST_IDLE);
        #10;
        i_reset = 1'b1;
        wait_ticks(32);

        applyStimulus(8'hA5, 2'b11, 1'b0);
        wait_ticks(32);

        // Short low glitch on an idle line must be rejected as a false start.
        i_rx = 1'b0;
        wait_ticks(4);
        i_rx = 1'b1;
        wait_ticks(32);
        checkOutput("glitch_state", dut.state, ST_IDLE);
        checkOutput("glitch_data", o_data, last_data);
        checkOutput("glitch_no_done", done_count, expected_done);

        applyStimulus(8'h3C, 2'b01, 1'b0);
        wait_ticks(32);
        applyStimulus(8'h81, 2'b11, 1'b0);
        wait_ticks(32);

        applyStimulus(8'h00, 2'b11, 1'b0);
        applyStimulus(8'hFF, 2'b11, 1'b0);
        wait_ticks(32);

        // Reset in the middle of the data bits of 0x5A, then resend it.
        i_rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            i_rx = 1'(8'h5A >> i);
            wait_ticks(16);
        end
        @(negedge i_clk);
        i_reset = 1'b0;
        i_rx    = 1'b1;
        #1;
        checkOutput("midreset_data", o_data, 8'h00);
        checkOutput("midreset_done", o_rx_done, 1'b0);
        checkOutput("midreset_ferr", o_frame_error, 1'b0);
        last_data = 8'h00;
        repeat (10) @(negedge i_clk);
        i_reset = 1'b1;
        wait_ticks(32);
        checkOutput("midreset_no_done", done_count, expected_done);
        applyStimulus(8'h5A, 2'b11, 1'b0);
        wait_ticks(32);

        applyStimulus(8'hC3, 2'b11, 1'b1);
        wait_ticks(32);

        for (int n = 0; n < 20; n++) begin
            logic [7:0] d;
            logic [1:0] sv;
            d  = 8'($urandom_range(0, 255));
            sv = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            applyStimulus(d, sv, 1'b0);
            wait_ticks($urandom_range(0, 40));
        end
        wait_ticks(48);

        checkOutput("all_frames_done", done_count, expected_done);
        checkOutput("queue_empty", expected_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
